// File: rtl/mem_sched.sv
// mem_sched: memory-request scheduler between the L1 icache/dcache and the
// single-ported main memory.
//   - One-entry request buffer per requester, round-robin grant.
//   - One block transaction in flight: IDLE -> ISSUE -> WAIT -> RESP.
//   - Responses are routed back to the owning cache as one-cycle pulses.
//   - An 8-bit saturating watchdog raises a sticky timeout_err in WAIT.
// Ports:
//   clk, rst_aL                 clock, asynchronous active-low reset
//   icache_req_* / icache_resp_*  icache read request / response
//   dcache_req_* / dcache_resp_*  dcache read/write request / response
//   mem_req_* / mem_resp_*      main-memory request pulse / response
//   timeout_err                 sticky watchdog error
// Optional build macro MEM_SCHED_STATS_EN adds the 32-bit wrapping counters
// stat_icache_grants, stat_dcache_grants and stat_wait_cycles.
module mem_sched #(
    parameter int unsigned BLOCK_ADDR_WIDTH = 26,
    parameter int unsigned BLOCK_DATA_WIDTH = 64,
    parameter int unsigned WATCHDOG_CYCLES  = 255
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    output logic                        icache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
    input  logic                        dcache_req_valid,
    input  logic                        dcache_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
    output logic                        dcache_req_ready,
    output logic                        dcache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data,
    output logic                        mem_req_valid,
    output logic                        mem_req_cache_type,
    output logic                        mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
    input  logic                        mem_resp_valid,
    input  logic                        mem_resp_cache_type,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
    output logic                        timeout_err
`ifdef MEM_SCHED_STATS_EN
    ,
    output logic [31:0]                 stat_icache_grants,
    output logic [31:0]                 stat_dcache_grants,
    output logic [31:0]                 stat_wait_cycles
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    localparam logic [7:0] WD_LIMIT = 8'(WATCHDOG_CYCLES);

    state_t                      r_state;
    logic                        r_ib_full;
    logic [BLOCK_ADDR_WIDTH-1:0] r_ib_addr;
    logic                        r_db_full;
    logic                        r_db_type;
    logic [BLOCK_ADDR_WIDTH-1:0] r_db_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_db_data;
    logic                        r_rr_last_d;   // 1: dcache granted last
    logic                        r_mem_req_valid;
    logic                        r_issue_cache;
    logic                        r_issue_type;
    logic [BLOCK_ADDR_WIDTH-1:0] r_issue_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_issue_data;
    logic                        r_iresp_valid;
    logic [BLOCK_DATA_WIDTH-1:0] r_iresp_data;
    logic                        r_dresp_valid;
    logic [BLOCK_DATA_WIDTH-1:0] r_dresp_data;
    logic [7:0]                  r_wd;
    logic                        r_timeout;

    logic                        w_grant_d;
    logic                        w_any_full;
    logic [7:0]                  w_wd_next;

    // dcache wins when it is the only full buffer, or when both are full and
    // icache was granted last.
    assign w_any_full = r_ib_full | r_db_full;
    assign w_grant_d  = r_db_full & (~r_ib_full | ~r_rr_last_d);
    assign w_wd_next  = (r_wd == 8'hFF) ? 8'hFF : r_wd + 8'd1;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state         <= ST_IDLE;
            r_ib_full       <= 1'b0;
            r_ib_addr       <= '0;
            r_db_full       <= 1'b0;
            r_db_type       <= 1'b0;
            r_db_addr       <= '0;
            r_db_data       <= '0;
            r_rr_last_d     <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_issue_cache   <= 1'b0;
            r_issue_type    <= 1'b0;
            r_issue_addr    <= '0;
            r_issue_data    <= '0;
            r_iresp_valid   <= 1'b0;
            r_iresp_data    <= '0;
            r_dresp_valid   <= 1'b0;
            r_dresp_data    <= '0;
            r_wd            <= '0;
            r_timeout       <= 1'b0;
        end else begin
            r_mem_req_valid <= 1'b0;
            r_iresp_valid   <= 1'b0;
            r_iresp_data    <= '0;
            r_dresp_valid   <= 1'b0;
            r_dresp_data    <= '0;

            // Accepts: a full buffer is never granted and accepted on the
            // same edge because ready is low while it is full.
            if (icache_req_valid && !r_ib_full) begin
                r_ib_full <= 1'b1;
                r_ib_addr <= icache_req_block_addr;
            end
            if (dcache_req_valid && !r_db_full) begin
                r_db_full <= 1'b1;
                r_db_type <= dcache_req_type;
                r_db_addr <= dcache_req_block_addr;
                r_db_data <= dcache_req_block_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_full) begin
                        if (w_grant_d) begin
                            r_issue_cache <= 1'b1;
                            r_issue_type  <= r_db_type;
                            r_issue_addr  <= r_db_addr;
                            r_issue_data  <= r_db_data;
                            r_db_full     <= 1'b0;
                            r_rr_last_d   <= 1'b1;
                        end else begin
                            r_issue_cache <= 1'b0;
                            r_issue_type  <= 1'b0;
                            r_issue_addr  <= r_ib_addr;
                            r_issue_data  <= '0;
                            r_ib_full     <= 1'b0;
                            r_rr_last_d   <= 1'b0;
                        end
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd <= w_wd_next;
                    if (w_wd_next == WD_LIMIT) begin
                        r_timeout <= 1'b1;
                    end
                    if (mem_resp_valid && (mem_resp_cache_type == r_issue_cache)) begin
                        if (r_issue_cache) begin
                            r_dresp_valid <= 1'b1;
                            r_dresp_data  <= r_issue_type ? '0 : mem_resp_block_data;
                        end else begin
                            r_iresp_valid <= 1'b1;
                            r_iresp_data  <= mem_resp_block_data;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign icache_req_ready       = ~r_ib_full;
    assign dcache_req_ready       = ~r_db_full;
    assign icache_resp_valid      = r_iresp_valid;
    assign icache_resp_block_data = r_iresp_data;
    assign dcache_resp_valid      = r_dresp_valid;
    assign dcache_resp_block_data = r_dresp_data;
    assign mem_req_valid          = r_mem_req_valid;
    assign mem_req_cache_type     = r_issue_cache;
    assign mem_req_type           = r_issue_type;
    assign mem_req_block_addr     = r_issue_addr;
    assign mem_req_block_data     = r_issue_data;
    assign timeout_err            = r_timeout;

`ifdef MEM_SCHED_STATS_EN
    logic [31:0] r_stat_igrants;
    logic [31:0] r_stat_dgrants;
    logic [31:0] r_stat_wait;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_stat_igrants <= '0;
            r_stat_dgrants <= '0;
            r_stat_wait    <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any_full) begin
                if (w_grant_d) begin
                    r_stat_dgrants <= r_stat_dgrants + 32'd1;
                end else begin
                    r_stat_igrants <= r_stat_igrants + 32'd1;
                end
            end
            if (r_state == ST_WAIT) begin
                r_stat_wait <= r_stat_wait + 32'd1;
            end
        end
    end

    assign stat_icache_grants = r_stat_igrants;
    assign stat_dcache_grants = r_stat_dgrants;
    assign stat_wait_cycles   = r_stat_wait;
`endif

endmodule
